i8080_sys_ctrl: RTL and testbench

//   Responder end of the i8080 CPU bus (system-controller role). Latches the status word on SYNC,

---
 rtl/i8080_pkg.sv | 53 +++++
 rtl/i8080_sys_ctrl_if.sv | 43 ++++
 rtl/i8080_wait_gen.sv | 33 +++
 rtl/i8080_sys_ctrl.sv | 155 +++++++++++++++
 tb/tb_i8080_sys_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/i8080_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i8080_pkg
//  Description : Shared definitions for the i8080 system controller:
//                status-word bit positions, machine-cycle types, FSM states
//                and the status-word decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package i8080_pkg;

    // Bit positions inside the status word presented on the data bus at SYNC
    localparam int c_SB_INTA  = 0;
    localparam int c_SB_WO_N  = 1;
    localparam int c_SB_STACK = 2;
    localparam int c_SB_HLTA  = 3;
    localparam int c_SB_OUT   = 4;
    localparam int c_SB_M1    = 5;
    localparam int c_SB_INP   = 6;
    localparam int c_SB_MEMR  = 7;

    typedef enum logic [2:0] {
        CYC_NONE = 3'd0,
        CYC_MEMR = 3'd1,
        CYC_MEMW = 3'd2,
        CYC_INP  = 3'd3,
        CYC_OUT  = 3'd4,
        CYC_INTA = 3'd5,
        CYC_HLTA = 3'd6
    } cyc_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_XFER  = 2'd3
    } state_t;

    // Priority decode: INTA > HLTA > MEMR > INP > OUT > MEMW (WO_n low).
    // STACK and M1 only qualify a memory cycle and do not change its type.
    function automatic cyc_t decode_status(input logic [7:0] s);
        cyc_t c;
        if (s[c_SB_INTA])       c = CYC_INTA;
        else if (s[c_SB_HLTA])  c = CYC_HLTA;
        else if (s[c_SB_MEMR])  c = CYC_MEMR;
        else if (s[c_SB_INP])   c = CYC_INP;
        else if (s[c_SB_OUT])   c = CYC_OUT;
        else if (!s[c_SB_WO_N]) c = CYC_MEMW;
        else                    c = CYC_NONE;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i8080_sys_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : i8080_sys_ctrl_if
//  Description : CPU-side bus plus back-end request/response signals of the
//                i8080 system controller. 'slave' is the controller view,
//                'master' is the CPU / back-end view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface i8080_sys_ctrl_if;
    // CPU side
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_doe;
    logic        cpu_sync;
    logic        cpu_dbin;
    logic        cpu_write_n;
    logic        cpu_ready;
    // Back-end side
    logic [15:0] bk_addr;
    logic [7:0]  bk_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        io_rd;
    logic        io_wr;
    logic [7:0]  bk_rdata;
    logic [7:0]  int_vector;
    logic        int_ack;
    logic        bus_err;

    modport slave (
        input  cpu_addr, cpu_din, cpu_sync, cpu_dbin, cpu_write_n, bk_rdata, int_vector,
        output cpu_dout, cpu_doe, cpu_ready, bk_addr, bk_wdata,
               mem_rd, mem_wr, io_rd, io_wr, int_ack, bus_err
    );

    modport master (
        output cpu_addr, cpu_din, cpu_sync, cpu_dbin, cpu_write_n, bk_rdata, int_vector,
        input  cpu_dout, cpu_doe, cpu_ready, bk_addr, bk_wdata,
               mem_rd, mem_wr, io_rd, io_wr, int_ack, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/i8080_wait_gen.sv
`default_nettype none
// ============================================================================
//  Module      : i8080_wait_gen
//  Description : Loadable down-counter for READY wait-state insertion.
//                Loaded with WAIT_STATES on i_load; READY is high whenever
//                the count is zero, so READY is low for exactly WAIT_STATES
//                cycles after each load. Saturates at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module i8080_wait_gen #(
    parameter int WAIT_STATES = 1
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_load,
    output logic o_ready
);

    localparam logic [3:0] c_LOAD = 4'(WAIT_STATES);

    logic [3:0] r_cnt;

    // Reload on every status latch, otherwise count down to zero and hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                r_cnt <= 4'd0;
        else if (i_load)        r_cnt <= c_LOAD;
        else if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end

    assign o_ready = (r_cnt == 4'd0);

endmodule
`default_nettype wire

// File: rtl/i8080_sys_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : i8080_sys_ctrl
//  Description : Responder end of the i8080 CPU bus. Latches the status word
//                on SYNC, decodes the machine cycle, generates READY with
//                WAIT_STATES wait cycles, issues one-cycle memory/IO strobes
//                and returns read data or the interrupt vector under DBIN.
//  Options     : SYS_CTRL_BUS_ERR_EN - enables the sticky bus_err protocol
//                checker (sync outside IDLE, DBIN with WRITE_n low, write in
//                a read/INTA cycle). Undefined: bus_err tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module i8080_sys_ctrl
    import i8080_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  wire             clk,
    input  wire             rst,
    i8080_sys_ctrl_if.slave bus
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_range_err
        $error("i8080_sys_ctrl: WAIT_STATES must be in 0..15");
    end

    state_t      r_state;
    cyc_t        r_cyc;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rd_buf;
    logic        r_mem_rd;
    logic        r_io_rd;
    logic        r_mem_wr;
    logic        r_io_wr;
    logic        r_int_ack;
    logic        r_rd_pend;   // back-end data is valid on bk_rdata this cycle
    logic        r_seen;      // a dbin or write phase has been observed
    logic        r_wr_done;   // write strobe already issued in this bus cycle

    logic        w_ready;
    cyc_t        w_dec;
    logic        w_active;
    logic        w_is_rd;
    logic        w_is_wr;
    logic        w_is_inta;
    logic        w_wr_allow;
    logic        w_wr_fire;

    i8080_wait_gen #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_gen (
        .clk     (clk),
        .rst     (rst),
        .i_load  (bus.cpu_sync),
        .o_ready (w_ready)
    );

    assign w_dec     = decode_status(bus.cpu_din);
    assign w_active  = (r_state == ST_WAIT) || (r_state == ST_XFER);
    assign w_is_rd   = (r_cyc == CYC_MEMR) || (r_cyc == CYC_INP);
    assign w_is_wr   = (r_cyc == CYC_MEMW) || (r_cyc == CYC_OUT);
    assign w_is_inta = (r_cyc == CYC_INTA);
    assign w_wr_fire = w_active && w_is_wr && !bus.cpu_write_n && !r_wr_done && w_wr_allow;

    // Bus-cycle FSM with registered strobes; SYNC in any state restarts the cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cyc     <= CYC_NONE;
            r_addr    <= 16'h0000;
            r_wdata   <= 8'h00;
            r_rd_buf  <= 8'h00;
            r_mem_rd  <= 1'b0;
            r_io_rd   <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_io_wr   <= 1'b0;
            r_int_ack <= 1'b0;
            r_rd_pend <= 1'b0;
            r_seen    <= 1'b0;
            r_wr_done <= 1'b0;
        end else begin
            r_mem_rd  <= 1'b0;
            r_io_rd   <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_io_wr   <= 1'b0;
            r_int_ack <= 1'b0;
            r_rd_pend <= r_mem_rd || r_io_rd;
            if (r_rd_pend) r_rd_buf <= bus.bk_rdata;

            if (bus.cpu_sync) begin
                r_state   <= ST_LATCH;
                r_cyc     <= w_dec;
                r_addr    <= bus.cpu_addr;
                r_int_ack <= (w_dec == CYC_INTA);
                r_rd_pend <= 1'b0;
                r_seen    <= 1'b0;
                r_wr_done <= 1'b0;
            end else begin
                if (w_active && (bus.cpu_dbin || !bus.cpu_write_n)) r_seen <= 1'b1;
                if (w_wr_fire) begin
                    r_wdata   <= bus.cpu_din;
                    r_mem_wr  <= (r_cyc == CYC_MEMW);
                    r_io_wr   <= (r_cyc == CYC_OUT);
                    r_wr_done <= 1'b1;
                end
                case (r_state)
                    ST_IDLE:  r_state <= ST_IDLE;
                    ST_LATCH: begin
                        r_mem_rd <= (r_cyc == CYC_MEMR);
                        r_io_rd  <= (r_cyc == CYC_INP);
                        r_state  <= ST_WAIT;
                    end
                    ST_WAIT:  if (w_ready) r_state <= ST_XFER;
                    ST_XFER:  if (r_seen && !bus.cpu_dbin && bus.cpu_write_n) r_state <= ST_IDLE;
                    default:  r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef SYS_CTRL_BUS_ERR_EN
    logic r_bus_err;

    // Sticky protocol-violation flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_err <= 1'b0;
        end else if ((bus.cpu_sync && r_state != ST_IDLE) ||
                     (bus.cpu_dbin && !bus.cpu_write_n) ||
                     (!bus.cpu_write_n && r_state != ST_IDLE && (w_is_rd || w_is_inta))) begin
            r_bus_err <= 1'b1;
        end
    end

    assign bus.bus_err = r_bus_err;
    assign w_wr_allow  = !bus.cpu_dbin;   // a write colliding with dbin is dropped
`else
    assign bus.bus_err = 1'b0;
    assign w_wr_allow  = 1'b1;
`endif

    assign bus.cpu_ready = w_ready;
    assign bus.cpu_doe   = bus.cpu_dbin && w_active && (w_is_rd || w_is_inta);
    assign bus.cpu_dout  = w_is_inta ? bus.int_vector : r_rd_buf;
    assign bus.bk_addr   = r_addr;
    assign bus.bk_wdata  = r_wdata;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.io_rd     = r_io_rd;
    assign bus.io_wr     = r_io_wr;
    assign bus.int_ack   = r_int_ack;

endmodule
`default_nettype wire

// File: tb/tb_i8080_sys_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i8080_sys_ctrl
//  Description : Directed bench for i8080_sys_ctrl. Three instances with
//                WAIT_STATES = 0, 1, 3 share one stimulus; the WAIT_STATES=1
//                instance is the main target, the others check READY length.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i8080_sys_ctrl;

`ifdef SYS_CTRL_BUS_ERR_EN
    localparam logic c_BERR = 1'b1;
`else
    localparam logic c_BERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_din = 8'h00;
    logic        cpu_sync = 1'b0;
    logic        cpu_dbin = 1'b0;
    logic        cpu_write_n = 1'b1;
    logic [7:0]  int_vector = 8'hD7;
    logic [7:0]  bk_rdata = 8'hEE;
    logic [7:0]  rd_val = 8'hA5;

    always #5 clk = ~clk;

    i8080_sys_ctrl_if bus0 ();
    i8080_sys_ctrl_if bus1 ();
    i8080_sys_ctrl_if bus3 ();

    assign bus0.cpu_addr = cpu_addr;    assign bus1.cpu_addr = cpu_addr;    assign bus3.cpu_addr = cpu_addr;
    assign bus0.cpu_din = cpu_din;      assign bus1.cpu_din = cpu_din;      assign bus3.cpu_din = cpu_din;
    assign bus0.cpu_sync = cpu_sync;    assign bus1.cpu_sync = cpu_sync;    assign bus3.cpu_sync = cpu_sync;
    assign bus0.cpu_dbin = cpu_dbin;    assign bus1.cpu_dbin = cpu_dbin;    assign bus3.cpu_dbin = cpu_dbin;
    assign bus0.cpu_write_n = cpu_write_n; assign bus1.cpu_write_n = cpu_write_n; assign bus3.cpu_write_n = cpu_write_n;
    assign bus0.int_vector = int_vector; assign bus1.int_vector = int_vector; assign bus3.int_vector = int_vector;
    assign bus0.bk_rdata = bk_rdata;    assign bus1.bk_rdata = bk_rdata;    assign bus3.bk_rdata = bk_rdata;

    i8080_sys_ctrl #(.WAIT_STATES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    i8080_sys_ctrl #(.WAIT_STATES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    i8080_sys_ctrl #(.WAIT_STATES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    // Back-end model: data valid exactly one cycle after a read request
    always begin
        @(negedge clk);
        if (bus1.mem_rd || bus1.io_rd) begin
            @(posedge clk); #1 bk_rdata = rd_val;
            @(posedge clk); #1 bk_rdata = 8'hEE;
        end
    end

    // Event counters, sampled mid-cycle
    int n_mrd = 0, n_mwr = 0, n_ird = 0, n_iwr = 0, n_ack = 0;
    int n_r0 = 0, n_r1 = 0, n_r3 = 0;
    always @(negedge clk) begin
        if (bus1.mem_rd)     n_mrd <= n_mrd + 1;
        if (bus1.mem_wr)     n_mwr <= n_mwr + 1;
        if (bus1.io_rd)      n_ird <= n_ird + 1;
        if (bus1.io_wr)      n_iwr <= n_iwr + 1;
        if (bus1.int_ack)    n_ack <= n_ack + 1;
        if (!bus0.cpu_ready) n_r0  <= n_r0 + 1;
        if (!bus1.cpu_ready) n_r1  <= n_r1 + 1;
        if (!bus3.cpu_ready) n_r3  <= n_r3 + 1;
    end

    int b_mrd, b_mwr, b_ird, b_iwr, b_ack, b_r0, b_r1, b_r3;
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_mrd = n_mrd; b_mwr = n_mwr; b_ird = n_ird; b_iwr = n_iwr; b_ack = n_ack;
        b_r0 = n_r0; b_r1 = n_r1; b_r3 = n_r3;
    endtask

    task automatic chk_strobes(input string tag, input int mrd, input int mwr,
                               input int ird, input int iwr, input int ack);
        chk({tag, "_mem_rd"},  32'(n_mrd - b_mrd), 32'(mrd));
        chk({tag, "_mem_wr"},  32'(n_mwr - b_mwr), 32'(mwr));
        chk({tag, "_io_rd"},   32'(n_ird - b_ird), 32'(ird));
        chk({tag, "_io_wr"},   32'(n_iwr - b_iwr), 32'(iwr));
        chk({tag, "_int_ack"}, 32'(n_ack - b_ack), 32'(ack));
    endtask

    task automatic chk_ready(input string tag);
        chk({tag, "_rdylow_ws0"}, 32'(n_r0 - b_r0), 32'd0);
        chk({tag, "_rdylow_ws1"}, 32'(n_r1 - b_r1), 32'd1);
        chk({tag, "_rdylow_ws3"}, 32'(n_r3 - b_r3), 32'd3);
    endtask

    // One complete bus cycle; optional dbin phase (checked) or write phase
    task automatic run_cycle(input string tag, input logic [7:0] st, input logic [15:0] a,
                             input logic wr, input logic [7:0] wd, input int len,
                             input logic rd, input logic [7:0] exp_d);
        snap();
        cpu_addr = a; cpu_din = st; cpu_sync = 1'b1;
        step(1);
        cpu_sync = 1'b0; cpu_din = wr ? wd : 8'h00;
        step(5);
        if (rd) begin
            @(negedge clk);
            chk({tag, "_doe_pre"}, 32'(bus1.cpu_doe), 32'd0);
            step(1);
            cpu_dbin = 1'b1;
            @(negedge clk);
            chk({tag, "_doe"},       32'(bus1.cpu_doe),  32'd1);
            chk({tag, "_dout"},      32'(bus1.cpu_dout), 32'(exp_d));
            chk({tag, "_dout_ws3"},  32'(bus3.cpu_dout), 32'(exp_d));
            step(len);
            cpu_dbin = 1'b0;
            @(negedge clk);
            chk({tag, "_doe_post"}, 32'(bus1.cpu_doe), 32'd0);
        end else if (wr) begin
            cpu_write_n = 1'b0;
            step(len);
            cpu_write_n = 1'b1;
        end
        step(3);
        chk({tag, "_bk_addr"}, 32'(bus1.bk_addr), 32'(a));
    endtask

    initial begin
        // Reset values
        @(negedge clk); @(negedge clk);
        chk("rst_ready", 32'(bus1.cpu_ready), 32'd1);
        chk("rst_doe",   32'(bus1.cpu_doe),   32'd0);
        chk("rst_dout",  32'(bus1.cpu_dout),  32'd0);
        chk("rst_addr",  32'(bus1.bk_addr),   32'd0);
        chk("rst_wdata", 32'(bus1.bk_wdata),  32'd0);
        chk("rst_strb",  32'({bus1.mem_rd, bus1.mem_wr, bus1.io_rd, bus1.io_wr, bus1.int_ack}), 32'd0);
        chk("rst_berr",  32'(bus1.bus_err),   32'd0);
        step(1);
        rst = 1'b0;
        step(2);

        // Opcode fetch from 0x2000 (MEMR|M1|WO_n)
        rd_val = 8'hA5;
        run_cycle("memr", 8'hA2, 16'h2000, 1'b0, 8'h00, 2, 1'b1, 8'hA5);
        chk_strobes("memr", 1, 0, 0, 0, 0);
        chk_ready("memr");

        // Memory write 0x3C to 0x2400, write_n low for 3 cycles
        run_cycle("memw", 8'h00, 16'h2400, 1'b1, 8'h3C, 3, 1'b0, 8'h00);
        chk_strobes("memw", 0, 1, 0, 0, 0);
        chk("memw_wdata", 32'(bus1.bk_wdata), 32'h3C);
        chk_ready("memw");

        // OUT 0x03 with data 0x10
        run_cycle("out", 8'h10, 16'h0303, 1'b1, 8'h10, 2, 1'b0, 8'h00);
        chk_strobes("out", 0, 0, 0, 1, 0);
        chk("out_wdata", 32'(bus1.bk_wdata), 32'h10);

        // IN 0x01 returning 0x5E
        rd_val = 8'h5E;
        run_cycle("inp", 8'h42, 16'h0101, 1'b0, 8'h00, 1, 1'b1, 8'h5E);
        chk_strobes("inp", 0, 0, 1, 0, 0);
        chk_ready("inp");

        // Interrupt acknowledge returning RST 2 opcode
        run_cycle("inta", 8'h23, 16'h0000, 1'b0, 8'h00, 1, 1'b1, 8'hD7);
        chk_strobes("inta", 0, 0, 0, 0, 1);

        // Halt acknowledge: no strobes; controller remains in the transfer phase
        run_cycle("hlta", 8'h8A, 16'h0077, 1'b0, 8'h00, 1, 1'b0, 8'h00);
        chk_strobes("hlta", 0, 0, 0, 0, 0);
        chk_ready("hlta");
        chk("hlta_berr", 32'(bus1.bus_err), 32'd0);

        // Reset asserted in the wait phase of a memory read
        cpu_addr = 16'h3000; cpu_din = 8'h82; cpu_sync = 1'b1;
        step(1);
        cpu_sync = 1'b0; cpu_din = 8'h00;
        step(1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready_ws3", 32'(bus3.cpu_ready), 32'd1);
        chk("abort_ready",     32'(bus1.cpu_ready), 32'd1);
        chk("abort_doe",       32'(bus1.cpu_doe),   32'd0);
        chk("abort_addr",      32'(bus1.bk_addr),   32'd0);
        chk("abort_dout",      32'(bus1.cpu_dout),  32'd0);
        chk("abort_berr",      32'(bus1.bus_err),   32'd0);
        step(2);
        rst = 1'b0;
        snap();
        step(5);
        chk_strobes("post_rst", 0, 0, 0, 0, 0);
        chk("post_rst_addr", 32'(bus1.bk_addr), 32'd0);

        // Read cycle left hanging in the transfer phase, then a new SYNC
        cpu_addr = 16'h3000; cpu_din = 8'h82; cpu_sync = 1'b1;
        step(1);
        cpu_sync = 1'b0; cpu_din = 8'h00;
        step(5);
        chk("hang_berr", 32'(bus1.bus_err), 32'd0);
        snap();
        cpu_addr = 16'h0055; cpu_din = 8'h10; cpu_sync = 1'b1;
        step(1);
        cpu_sync = 1'b0; cpu_din = 8'h99;
        @(negedge clk);
        chk("relatch_addr", 32'(bus1.bk_addr), 32'h0055);
        chk("relatch_berr", 32'(bus1.bus_err), 32'(c_BERR));
        step(5);
        cpu_write_n = 1'b0;
        step(1);
        cpu_write_n = 1'b1;
        step(3);
        chk_strobes("relatch", 0, 0, 0, 1, 0);
        chk("relatch_wdata", 32'(bus1.bk_wdata), 32'h99);
        chk("relatch_berr_sticky", 32'(bus1.bus_err), 32'(c_BERR));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
